full_adder: RTL and testbench
=============================

# full_adder

One-bit full adder with a combinational path and a registered path. It adds operands a and b with a carry-in and produces sum and carry-out within the same cycle. The registered copies and a bit-serial carry-feedback mode let the block serve both as a ripple-carry building cell in the ALU and as a stand-alone LSB-first serial adder.

## Interface

Parameters:
- none

Ports:
- Clock is `clk`; reset is `rst_n`, asynchronous and active-low.
- clk  input  1  rising-edge clock for all registers
- rst_n  input  1  asynchronous active-low reset
- a  input  1  operand bit A
- b  input  1  operand bit B
- cin  input  1  external carry-in; used when serial=0
- en  input  1  register enable; tie to 1 for free-running capture
- serial  input  1  1 = carry-in taken from cout_q (bit-serial mode); 0 = carry-in taken from cin
- clr  input  1  synchronous clear of all registered outputs
- sum  output  1  combinational sum
- cout  output  1  combinational carry-out
- sum_q  output  1  registered sum
- cout_q  output  1  registered carry-out; also the serial carry state
- valid_q  output  1  1 when sum_q/cout_q hold a captured result

## Operation

- Effective carry: cin_eff = serial ? cout_q : cin.
- sum = a XOR b XOR cin_eff.
- cout = (a AND b) OR (a AND cin_eff) OR (b AND cin_eff).
- {cout,sum} equals the 2-bit arithmetic value a + b + cin_eff for all 8 input combinations. Overflow is not possible; the maximum value is 3 = 2'b11.
- Register update on the rising edge of clk, in priority order:
  - clr=1: sum_q←0, cout_q←0, valid_q←0. This takes priority over en.
  - en=1: sum_q←sum, cout_q←cout, valid_q←1.
  - en=0: all registers hold.
- Serial mode, LSB first:
  - Assert clr for one cycle to zero the carry.
  - Hold serial=1 and en=1.
  - Present one bit pair per cycle; sum_q is the result bit stream.
  - After the last bit, cout_q is the final carry-out.
- serial may change at any cycle. The combinational outputs follow immediately, with no glitch requirement beyond normal combinational settling.
- No X propagation from the registers after reset. Combinational outputs are X only if the inputs are X.

## Timing

- Combinational path (sum, cout): zero cycles. Outputs are valid within the same cycle and settle within one combinational delay of any input change.
- Registered path: one-cycle latency. sum_q/cout_q reflect the inputs sampled at the preceding rising edge with en=1.
- Reset (rst_n=0): immediately, with no clock required, sum_q=0, cout_q=0, valid_q=0.
  - Combinational outputs stay live during reset.
  - With serial=1 during reset, cin_eff=0.
- Reset deasserts synchronously with respect to the first capture. The first edge with rst_n=1 and en=1 captures normally.
- Reset mid serial operation: the carry is lost and the operation restarts from carry 0.
- clr and en both high on the same edge: clr wins, and valid_q=0.

## Test plan

- Truth table, serial=0, en=1: step {cin,b,a} from 000 to 111 at 10 ns intervals. Required {cout,sum}: 00, 01, 01, 10, 01, 10, 10, 11.
- Registered latency: a=1, b=1, cin=0, en=1 at edge N. Required: sum_q=0, cout_q=1, valid_q=1 after edge N, and not before.
- Serial add 3+1 (LSB first): clr for one cycle, then serial=1 with (a,b) = (1,1), (1,0), (0,0). Required sum_q stream: 0, 0, 1. Required final cout_q=0, giving the result 4.
- Async reset mid-operation: drop rst_n between clock edges with cout_q=1. Required: sum_q, cout_q and valid_q go to 0 immediately; with serial=1, a=1, b=0, sum=1 combinationally.
- clr priority and hold: clr=1 with en=1 requires all registers to be 0. Then en=0 with toggling a/b/cin requires sum_q, cout_q and valid_q to hold.

Source files
------------

// File: rtl/full_adder.sv
// One-bit full adder with a combinational sum/carry path and a registered copy.
// Serial mode feeds cout_q back as carry-in, so the cell can run as an LSB-first serial adder.
//
// Ports:
//   clk     : rising-edge clock for all registers
//   rst_n   : asynchronous active-low reset
//   a, b    : operand bits
//   cin     : external carry-in, used when serial=0
//   en      : register enable
//   serial  : 1 = carry-in from cout_q, 0 = carry-in from cin
//   clr     : synchronous clear of registered outputs, overrides en
//   sum     : combinational sum
//   cout    : combinational carry-out
//   sum_q   : registered sum
//   cout_q  : registered carry-out, also the serial carry state
//   valid_q : registered outputs hold a captured result
module full_adder (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic en,
    input  logic serial,
    input  logic clr,
    output logic sum,
    output logic cout,
    output logic sum_q,
    output logic cout_q,
    output logic valid_q
);

    logic cin_eff;
    logic sum_d;
    logic cout_d;
    logic valid_d;

    // cout_q is zero during reset, so serial mode sees carry 0 then.
    always_comb begin
        cin_eff = serial ? cout_q : cin;
        sum     = a ^ b ^ cin_eff;
        cout    = (a & b) | (a & cin_eff) | (b & cin_eff);
    end

    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        valid_d = valid_q;
        if (clr) begin
            sum_d   = 1'b0;
            cout_d  = 1'b0;
            valid_d = 1'b0;
        end else if (en) begin
            sum_d   = sum;
            cout_d  = cout;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= 1'b0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Testbench for full_adder: directed steps, scoreboard queue for registered results,
// and an independent behavioural model of the carry state.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst_n;
    logic a, b, cin, en, serial, clr;
    logic sum, cout, sum_q, cout_q, valid_q;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [2:0] exp;
    } sb_t;

    sb_t sb[$];

    logic m_sum, m_cout, m_valid;

    full_adder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .en      (en),
        .serial  (serial),
        .clr     (clr),
        .sum     (sum),
        .cout    (cout),
        .sum_q   (sum_q),
        .cout_q  (cout_q),
        .valid_q (valid_q)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [2:0] obs,
                       input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check the combinational
    // result, push the registered expectation, then compare after the edge.
    task automatic step(input string tag, input logic ia, input logic ib,
                        input logic icin, input logic ien,
                        input logic iser, input logic iclr);
        logic       ce;
        logic [1:0] tot;
        sb_t        e;
        @(negedge clk);
        a = ia; b = ib; cin = icin; en = ien; serial = iser; clr = iclr;
        #1;
        ce  = iser ? m_cout : icin;
        tot = 2'(ia) + 2'(ib) + 2'(ce);
        chk({tag, "_comb"}, {1'b0, cout, sum}, {1'b0, tot});
        if (iclr) begin
            m_sum = 0; m_cout = 0; m_valid = 0;
        end else if (ien) begin
            m_sum = tot[0]; m_cout = tot[1]; m_valid = 1;
        end
        e.tag = {tag, "_reg"};
        e.exp = {m_valid, m_cout, m_sum};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 3'b000, 3'b111);
        end else begin
            e = sb.pop_front();
            chk(e.tag, {valid_q, cout_q, sum_q}, e.exp);
        end
    endtask

    logic [1:0] tt [8];

    initial begin
        tt[0] = 2'b00; tt[1] = 2'b01; tt[2] = 2'b01; tt[3] = 2'b10;
        tt[4] = 2'b01; tt[5] = 2'b10; tt[6] = 2'b10; tt[7] = 2'b11;
        m_sum = 0; m_cout = 0; m_valid = 0;

        rst_n = 0;
        a = 1; b = 0; cin = 0; en = 1; serial = 1; clr = 0;
        #3;
        chk("reset_regs", {valid_q, cout_q, sum_q}, 3'b000);
        chk("reset_comb_serial", {cout, sum}, 3'b001);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            @(negedge clk);
            a = v[0]; b = v[1]; cin = v[2]; en = 1; serial = 0; clr = 0;
            #1;
            chk($sformatf("truth_%0d", i), {1'b0, cout, sum}, {1'b0, tt[i]});
            @(posedge clk);
            #1;
            m_sum = tt[i][0]; m_cout = tt[i][1]; m_valid = 1;
            chk($sformatf("truth_reg_%0d", i),
                {valid_q, cout_q, sum_q}, {1'b1, tt[i]});
        end

        step("clr_pre", 0, 0, 0, 1, 0, 1);
        @(negedge clk);
        a = 1; b = 1; cin = 0; en = 1; serial = 0; clr = 0;
        #1;
        chk("latency_before", {valid_q, cout_q, sum_q}, 3'b000);
        @(posedge clk);
        #1;
        chk("latency_after", {valid_q, cout_q, sum_q}, 3'b110);
        m_sum = 0; m_cout = 1; m_valid = 1;

        step("ser_clr", 1, 1, 1, 1, 1, 1);
        step("ser_b0", 1, 1, 0, 1, 1, 0);
        chk("ser_bit0", {2'b00, sum_q}, 3'b000);
        step("ser_b1", 1, 0, 0, 1, 1, 0);
        chk("ser_bit1", {2'b00, sum_q}, 3'b000);
        step("ser_b2", 0, 0, 0, 1, 1, 0);
        chk("ser_bit2_cout", {1'b0, cout_q, sum_q}, 3'b001);

        step("arm_carry", 1, 1, 0, 1, 0, 0);
        #2;
        a = 1; b = 0; cin = 0; serial = 1;
        rst_n = 0;
        #1;
        chk("async_rst_regs", {valid_q, cout_q, sum_q}, 3'b000);
        chk("async_rst_comb", {cout, sum}, 3'b001);
        m_sum = 0; m_cout = 0; m_valid = 0;
        @(negedge clk);
        rst_n = 1;
        step("post_rst", 1, 0, 0, 1, 1, 0);

        step("clr_en", 1, 1, 1, 1, 0, 1);
        chk("clr_prio", {valid_q, cout_q, sum_q}, 3'b000);
        step("load", 1, 0, 1, 1, 0, 0);
        step("hold0", 0, 1, 1, 0, 0, 0);
        step("hold1", 1, 1, 0, 0, 0, 0);
        step("hold2", 0, 0, 1, 0, 1, 0);
        step("hold3", 1, 1, 1, 0, 0, 0);
        chk("hold_final", {valid_q, cout_q, sum_q}, 3'b110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
